// File: rtl/rf_black_widow_mem_issue_sched_if.sv
// Request payload type and the handshake bundle between the scheduler, the
// store/memory request queue, the load-miss requester and the data-memory port.
// master: scheduler side; slave: queue/load/memory environment side.
// Optional perf counter signals exist only when MEMQ_SCHED_PERF_EN is defined.
package rf_black_widow_mem_pkg;
    typedef struct packed {
        logic [7:0]  tid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } MemoryRequest;
endpackage

interface rf_black_widow_mem_issue_sched_if;
    import rf_black_widow_mem_pkg::*;

    logic         q_valid;
    MemoryRequest q_i;
    logic         q_rd;
    logic         ld_req;
    MemoryRequest ld_i;
    logic         ld_ack;
    logic         m_req;
    MemoryRequest m_o;
    logic         m_ack;
    logic         m_rty;
    logic         busy;
    logic         err;
    logic [7:0]   err_tid;
    logic         err_clr;
`ifdef MEMQ_SCHED_PERF_EN
    logic [31:0]  perf_q_cnt;
    logic [31:0]  perf_ld_cnt;
    logic [31:0]  perf_rty_cnt;
`endif

    modport master (
        input  q_valid, q_i, ld_req, ld_i, m_ack, m_rty, err_clr,
        output q_rd, ld_ack, m_req, m_o, busy, err, err_tid
`ifdef MEMQ_SCHED_PERF_EN
        , output perf_q_cnt, perf_ld_cnt, perf_rty_cnt
`endif
    );

    modport slave (
        output q_valid, q_i, ld_req, ld_i, m_ack, m_rty, err_clr,
        input  q_rd, ld_ack, m_req, m_o, busy, err, err_tid
`ifdef MEMQ_SCHED_PERF_EN
        , input perf_q_cnt, perf_ld_cnt, perf_rty_cnt
`endif
    );
endinterface

// File: rtl/rf_black_widow_mem_issue_sched.sv
// Issue scheduler: arbitrates queue head vs load-miss requester onto the data-memory port.
// Latency: grant->m_req 1 cycle, m_ack->q_rd/ld_ack 1 cycle, back-to-back grants every 3 cycles.
// Backpressure: m_rty backs off RTY_DLY cycles (max MAX_RTY retries), TMO_CYC cycles without answer aborts.
// Ports: clk, rst_n (synchronous, active-low), bus (master modport: queue q_valid/q_i/q_rd,
//   load ld_req/ld_i/ld_ack, memory m_req/m_o/m_ack/m_rty, status busy/err/err_tid/err_clr).
// Optional: define MEMQ_SCHED_PERF_EN for perf_q_cnt/perf_ld_cnt/perf_rty_cnt counters.
module rf_black_widow_mem_issue_sched #(
    parameter int STARVE_LIM = 4,
    parameter int RTY_DLY    = 3,
    parameter int MAX_RTY    = 7,
    parameter int TMO_CYC    = 255
) (
    input logic clk,
    input logic rst_n,
    rf_black_widow_mem_issue_sched_if.master bus
);
    import rf_black_widow_mem_pkg::*;

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int RW = $clog2(MAX_RTY + 1);
    localparam int TW = $clog2(TMO_CYC + 1);
    localparam int DW = (RTY_DLY > 0) ? $clog2(RTY_DLY + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);
    localparam logic [RW-1:0] RTY_MAX    = RW'(MAX_RTY);
    localparam logic [TW-1:0] TMO_MAX    = TW'(TMO_CYC);
    localparam logic [DW-1:0] DLY_INIT   = DW'(RTY_DLY);

    typedef enum logic [1:0] {IDLE, ISSUE, RETRY, DONE} state_t;

    state_t       state, state_nxt;
    logic         src_ld;
    logic [SW-1:0] starve_cnt;
    logic [RW-1:0] rty_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [DW-1:0] dly;
    logic         m_req;
    MemoryRequest m_o;
    logic         err;
    logic [7:0]   err_tid;

    logic grant_ld, grant_q, do_retry, do_abort, do_reissue, tmo_inc, rty_evt;
    logic q_rd, ld_ack;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        grant_ld   = 1'b0;
        grant_q    = 1'b0;
        do_retry   = 1'b0;
        do_abort   = 1'b0;
        do_reissue = 1'b0;
        tmo_inc    = 1'b0;
        rty_evt    = 1'b0;
        q_rd       = 1'b0;
        ld_ack     = 1'b0;
        case (state)
            IDLE: begin
                // Loads win unless a queue entry has waited through STARVE_LIM load grants.
                if (bus.ld_req && (!bus.q_valid || starve_cnt < STARVE_MAX)) grant_ld = 1'b1;
                else if (bus.q_valid)                                       grant_q  = 1'b1;
                if (grant_ld || grant_q) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (bus.m_ack) begin
                    state_nxt = DONE;
                end else if (bus.m_rty) begin
                    rty_evt = 1'b1;
                    if (rty_cnt == RTY_MAX) begin
                        do_abort  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        do_retry  = 1'b1;
                        state_nxt = RETRY;
                    end
                end else if (tmo_cnt == TMO_MAX) begin
                    do_abort  = 1'b1;
                    state_nxt = DONE;
                end else begin
                    tmo_inc = 1'b1;
                end
            end
            RETRY: begin
                // dly counts the remaining idle cycles including this one.
                if (dly <= DW'(1)) begin
                    do_reissue = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            DONE: begin
                q_rd      = !src_ld;
                ld_ack    = src_ld;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_ld     <= 1'b0;
            starve_cnt <= '0;
            rty_cnt    <= '0;
            tmo_cnt    <= '0;
            dly        <= '0;
            m_req      <= 1'b0;
            m_o        <= '0;
            err        <= 1'b0;
            err_tid    <= '0;
        end else begin
            m_req <= (state_nxt == ISSUE);
            if (grant_ld || grant_q) begin
                m_o     <= grant_ld ? bus.ld_i : bus.q_i;
                src_ld  <= grant_ld;
                rty_cnt <= '0;
                tmo_cnt <= '0;
            end
            if (grant_q)
                starve_cnt <= '0;
            else if (grant_ld && bus.q_valid && starve_cnt < STARVE_MAX)
                starve_cnt <= starve_cnt + SW'(1);
            if (do_retry) begin
                rty_cnt <= rty_cnt + RW'(1);
                dly     <= DLY_INIT;
            end else if (state == RETRY) begin
                dly <= dly - DW'(1);
            end
            if (tmo_inc)    tmo_cnt <= tmo_cnt + TW'(1);
            if (do_reissue) tmo_cnt <= '0;
            if (do_abort) begin
                err     <= 1'b1;
                err_tid <= m_o.tid;
            end else if (bus.err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign bus.q_rd    = q_rd;
    assign bus.ld_ack  = ld_ack;
    assign bus.m_req   = m_req;
    assign bus.m_o     = m_o;
    assign bus.busy    = (state != IDLE);
    assign bus.err     = err;
    assign bus.err_tid = err_tid;

`ifdef MEMQ_SCHED_PERF_EN
    logic [31:0] perf_q_cnt, perf_ld_cnt, perf_rty_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_q_cnt   <= '0;
            perf_ld_cnt  <= '0;
            perf_rty_cnt <= '0;
        end else begin
            if (q_rd)    perf_q_cnt   <= perf_q_cnt + 32'd1;
            if (ld_ack)  perf_ld_cnt  <= perf_ld_cnt + 32'd1;
            if (rty_evt) perf_rty_cnt <= perf_rty_cnt + 32'd1;
        end
    end

    assign bus.perf_q_cnt   = perf_q_cnt;
    assign bus.perf_ld_cnt  = perf_ld_cnt;
    assign bus.perf_rty_cnt = perf_rty_cnt;
`endif
endmodule

// File: tb/tb_rf_black_widow_mem_issue_sched.sv
// Directed bench for the memory issue scheduler: arbitration table plus
// hand sequences for delayed ack, retry exhaustion, timeout, reset and perf counters.
module tb_rf_black_widow_mem_issue_sched;
    import rf_black_widow_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    rf_black_widow_mem_issue_sched_if bus();
    rf_black_widow_mem_issue_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // exp: 0 = no grant, 1 = queue grant, 2 = load grant
    typedef struct {
        logic       qv;
        logic [7:0] qt;
        logic       lv;
        logic [7:0] lt;
        int         exp;
        logic [7:0] etid;
    } vec_t;

    vec_t vt[9];

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic MemoryRequest mk(input logic [7:0] t);
        MemoryRequest r;
        r.tid   = t;
        r.we    = t[0];
        r.addr  = {24'h100000, t};
        r.wdata = {4{t}};
        return r;
    endfunction

    task automatic idle_inputs();
        bus.q_valid = 1'b0;
        bus.q_i     = '0;
        bus.ld_req  = 1'b0;
        bus.ld_i    = '0;
        bus.m_ack   = 1'b0;
        bus.m_rty   = 1'b0;
        bus.err_clr = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        bus.q_valid = v.qv;
        bus.q_i     = mk(v.qt);
        bus.ld_req  = v.lv;
        bus.ld_i    = mk(v.lt);
        if (v.exp == 0) begin
            bus.m_ack = 1'b1;   // ack outside ISSUE must be ignored
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_idle_mreq", idx), 32'(bus.m_req), 32'd0);
                chk($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
            end
            idle_inputs();
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d_mreq", idx), 32'(bus.m_req), 32'd1);
            chk($sformatf("v%0d_tid", idx), 32'(bus.m_o.tid), 32'(v.etid));
            bus.m_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_q_rd", idx), 32'(bus.q_rd), 32'(v.exp == 1));
            chk($sformatf("v%0d_ld_ack", idx), 32'(bus.ld_ack), 32'(v.exp == 2));
            chk($sformatf("v%0d_mreq_off", idx), 32'(bus.m_req), 32'd0);
            idle_inputs();
        end
    endtask

    task automatic do_txn(input logic is_ld, input logic [7:0] tid, input int n_rty);
        int left;
        int done;
        left = n_rty;
        done = 0;
        @(negedge clk);
        if (is_ld) begin
            bus.ld_req = 1'b1;
            bus.ld_i   = mk(tid);
        end else begin
            bus.q_valid = 1'b1;
            bus.q_i     = mk(tid);
        end
        for (int c = 0; c < 100 && done == 0; c++) begin
            @(negedge clk);
            bus.m_ack = 1'b0;
            bus.m_rty = 1'b0;
            if (bus.q_rd || bus.ld_ack) begin
                done = 1;
                chk("txn_src", 32'(bus.ld_ack), 32'(is_ld));
                idle_inputs();
            end else if (bus.m_req) begin
                chk("txn_tid", 32'(bus.m_o.tid), 32'(tid));
                if (left > 0) begin
                    bus.m_rty = 1'b1;
                    left--;
                end else begin
                    bus.m_ack = 1'b1;
                end
            end
        end
        chk("txn_done", 32'(done), 32'd1);
    endtask

    initial begin
        int n_iss, last, spacing_bad, seen, qrd_cnt;

        // Arbitration table; starve count carries from one row to the next.
        vt[0] = '{1'b1, 8'h05, 1'b0, 8'h00, 1, 8'h05};
        vt[1] = '{1'b0, 8'h00, 1'b1, 8'h21, 2, 8'h21};
        vt[2] = '{1'b1, 8'h06, 1'b1, 8'h22, 2, 8'h22};
        vt[3] = '{1'b1, 8'h06, 1'b1, 8'h23, 2, 8'h23};
        vt[4] = '{1'b1, 8'h06, 1'b1, 8'h24, 2, 8'h24};
        vt[5] = '{1'b1, 8'h06, 1'b1, 8'h25, 2, 8'h25};
        vt[6] = '{1'b1, 8'h06, 1'b1, 8'h26, 1, 8'h06};
        vt[7] = '{1'b1, 8'h07, 1'b1, 8'h27, 2, 8'h27};
        vt[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 0, 8'h00};

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mreq", 32'(bus.m_req), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_err_tid", 32'(bus.err_tid), 32'd0);
        chk("rst_m_o", 32'(bus.m_o.tid), 32'd0);
        chk("rst_q_rd", 32'(bus.q_rd), 32'd0);
        chk("rst_ld_ack", 32'(bus.ld_ack), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vt[i], i);

        // Delayed ack: m_ack two cycles after m_req, single q_rd one cycle later.
        @(negedge clk);
        bus.q_valid = 1'b1;
        bus.q_i     = mk(8'h05);
        @(negedge clk);
        chk("a_mreq", 32'(bus.m_req), 32'd1);
        chk("a_tid", 32'(bus.m_o.tid), 32'h05);
        @(negedge clk);
        chk("a_mreq_hold", 32'(bus.m_req), 32'd1);
        chk("a_q_rd_early", 32'(bus.q_rd), 32'd0);
        @(negedge clk);
        chk("a_tid_stable", 32'(bus.m_o.tid), 32'h05);
        bus.m_ack = 1'b1;
        @(negedge clk);
        chk("a_q_rd", 32'(bus.q_rd), 32'd1);
        idle_inputs();
        qrd_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.q_rd) qrd_cnt++;
        end
        chk("a_q_rd_once", 32'(qrd_cnt), 32'd0);

        // Retry exhaustion: 8 issues spaced RTY_DLY+1 apart, then abort and pop.
        @(negedge clk);
        bus.q_valid = 1'b1;
        bus.q_i     = mk(8'h09);
        bus.m_rty   = 1'b1;
        n_iss = 0; last = -1; spacing_bad = 0; seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.m_req) begin
                if (last >= 0 && c - last != 4) spacing_bad++;
                last = c;
                n_iss++;
            end
            if (bus.q_rd) begin
                seen = 1;
                chk("b_err", 32'(bus.err), 32'd1);
                chk("b_err_tid", 32'(bus.err_tid), 32'h09);
                idle_inputs();
            end
        end
        chk("b_seen_q_rd", 32'(seen), 32'd1);
        chk("b_issues", 32'(n_iss), 32'd8);
        chk("b_spacing", 32'(spacing_bad), 32'd0);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        chk("b_err_cleared", 32'(bus.err), 32'd0);

        // Timeout on a load with err_clr held: abort wins, ld_ack pulses.
        @(negedge clk);
        bus.ld_req  = 1'b1;
        bus.ld_i    = mk(8'h33);
        bus.err_clr = 1'b1;
        n_iss = 0; seen = 0;
        for (int c = 0; c < 400 && seen == 0; c++) begin
            @(negedge clk);
            if (bus.m_req) n_iss++;
            if (bus.ld_ack) begin
                seen = 1;
                chk("c_err", 32'(bus.err), 32'd1);
                chk("c_err_tid", 32'(bus.err_tid), 32'h33);
                chk("c_no_q_rd", 32'(bus.q_rd), 32'd0);
                idle_inputs();
            end
        end
        chk("c_seen_ld_ack", 32'(seen), 32'd1);
        chk("c_issue_cycles", 32'(n_iss), 32'd256);
        @(negedge clk);
        chk("c_err_sticky", 32'(bus.err), 32'd1);

        // Reset mid-ISSUE drops the request; the same head is re-issued afterwards.
        @(negedge clk);
        bus.q_valid = 1'b1;
        bus.q_i     = mk(8'h44);
        @(negedge clk);
        chk("d_mreq", 32'(bus.m_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("d_rst_mreq", 32'(bus.m_req), 32'd0);
        chk("d_rst_busy", 32'(bus.busy), 32'd0);
        chk("d_rst_q_rd", 32'(bus.q_rd), 32'd0);
        chk("d_rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("d_reissue_mreq", 32'(bus.m_req), 32'd1);
        chk("d_reissue_tid", 32'(bus.m_o.tid), 32'h44);
        bus.m_ack = 1'b1;
        @(negedge clk);
        chk("d_q_rd", 32'(bus.q_rd), 32'd1);
        idle_inputs();

        // Completion mix since reset: 3 queue, 2 load, 4 retries.
        do_txn(1'b0, 8'h50, 4);
        do_txn(1'b1, 8'h51, 0);
        do_txn(1'b1, 8'h52, 0);
        do_txn(1'b0, 8'h53, 0);
        @(negedge clk);
        chk("e_err", 32'(bus.err), 32'd0);
`ifdef MEMQ_SCHED_PERF_EN
        chk("perf_q_cnt", bus.perf_q_cnt, 32'd3);
        chk("perf_ld_cnt", bus.perf_ld_cnt, 32'd2);
        chk("perf_rty_cnt", bus.perf_rty_cnt, 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
